cordic_lin_mult_ctrl: RTL and testbench
=======================================

Name: cordic_lin_mult_ctrl

Overview:
- Iterative linear-mode CORDIC multiplier controller. Computes y = x*z in Q1.14 at one micro-rotation per clock.
- Directly upstream of the 16-bit signed approximate adder (A,B 16-bit in, O 17-bit sign-extended sum out). The controller drives the adder operands and registers its sum as the next y accumulator.
- The adder stays outside this block so the team can swap adder variants without touching the controller.

Parameters:
- WIDTH, 16, operand/result width (two's complement, Q1.(WIDTH-2)); must match adder input width.
- ITER, 14, number of micro-rotations (i = 0..ITER-1); ITER <= WIDTH-2.
- CNT_W, 4, iteration counter width; 2^CNT_W >= ITER.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands.
- x_in  in  WIDTH  multiplicand, signed Q1.14.
- z_in  in  WIDTH  multiplier, signed Q1.14.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y_out  out  WIDTH  product, signed Q1.14.
- z_res  out  WIDTH  residual angle after the last iteration (debug/error metric).
- add_a  out  WIDTH  adder operand A = y accumulator.
- add_b  out  WIDTH  adder operand B = +/-(x >>> i).
- add_o  in  WIDTH+1  adder sum, sign-extended.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, y_out=0, z_res=0, add_a=0, add_b=0, and all internal registers zero. Reset mid-RUN or mid-DONE aborts the operation: no out_valid, next cycle in IDLE.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch x=x_in, z=z_in, y=0, i=0, go to RUN.
  - RUN: in_ready=0. Each cycle: d=+1 if z>=0 (z==0 counts as positive), else -1. add_a=y; add_b = d>0 ? (x>>>i) : -(x>>>i), negated in WIDTH bits, arithmetic shift.
    - At the clock edge: y <= sat(add_o); z <= z - d*2^(14-i) (exact internal subtractor, WIDTH bits, wraps); i <= i+1.
    - When i==ITER-1 the update completes and state goes to DONE.
  - DONE: out_valid=1, y_out=y, z_res=z. Both are held stable until out_ready. On out_valid&out_ready go to IDLE.
- Outputs outside DONE: add_a/add_b are combinational from registered y/x/z/i and are 0 outside RUN. y_out and z_res hold their last values outside DONE.
- Saturation sat(): if add_o[WIDTH]!=add_o[WIDTH-1], y = add_o[WIDTH] ? 0x8000 : 0x7FFF. Otherwise y = add_o[WIDTH-1:0].
- Latency and throughput:
  - out_valid rises exactly ITER clock edges after the accepting edge (14 cycles at default).
  - With out_ready held at 1, out_valid is high for 1 cycle, then IDLE. Next accept is possible 1 cycle later, so throughput is one result per ITER+2 cycles.
  - No input accepted in RUN/DONE. Held in_valid is not consumed twice.
- Convergence domain: |z_in| < 2 - 2^-13. For |x|,|z| < 1, the result is exact-adder correct to within x*2^-13. Approximate-adder error is additive and not compensated here.

Decomposition:
- Shared package cordic_pkg: WIDTH/FRAC constants, state enum (IDLE, RUN, DONE), sat_q114 function, angle-step constant 2^(FRAC-i) generation.
- No sub-module inside. The adder is instantiated one level up, next to this controller, in the multiplier top.

Test Plan (bench drives an exact behavioural adder on add_o unless stated):
- x=0x2000, z=0x2000 -> after 14 cycles out_valid=1, y_out=0x1001, z_res=0xFFFE.
- x=0x2000, z=0x0000 -> y_out=0x0001 (z==0 takes d=+1 path).
- x=0x2000, z=0xE000 -> y_out=0xF001. Also check add_b=0xE000 on the first RUN cycle.
- Backpressure: out_ready=0 for 5 cycles after out_valid; y_out stable, in_ready=0, second in_valid ignored. Then out_ready=1 -> IDLE, and the second operand pair is accepted next cycle.
- Injected adder overflow (add_o=0x0_8000 on one RUN cycle) -> y saturates to 0x7FFF; add_o=0x1_7FFF -> 0x8000.
- rst asserted at RUN cycle 7 -> next cycle IDLE, in_ready=1, out_valid never pulses. New op afterwards is bit-exact with the first test.

Source files
------------

// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the linear-mode CORDIC multiplier slice:
//   - Q1.14 word width and fraction-bit constants
//   - controller state encoding
//   - sat_q114(): collapse a 17-bit sign-extended adder sum into Q1.14
//   - angle_step(): the residual-angle decrement 2^(FRAC-i) for micro-rotation i
// -----------------------------------------------------------------------------
package cordic_pkg;

  localparam int CORDIC_WIDTH = 16;
  localparam int CORDIC_FRAC  = CORDIC_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // If the two top bits of the extended sum disagree, the sum left the
  // Q1.14 range; clamp to the most negative / most positive code.
  function automatic logic [CORDIC_WIDTH-1:0] sat_q114(input logic [CORDIC_WIDTH:0] sum);
    logic [CORDIC_WIDTH-1:0] res;
    if (sum[CORDIC_WIDTH] != sum[CORDIC_WIDTH-1]) begin
      if (sum[CORDIC_WIDTH]) begin
        res = {1'b1, {(CORDIC_WIDTH-1){1'b0}}};
      end else begin
        res = {1'b0, {(CORDIC_WIDTH-1){1'b1}}};
      end
    end else begin
      res = sum[CORDIC_WIDTH-1:0];
    end
    return res;
  endfunction

  // 2^(FRAC-i) in Q1.14; i = 0 gives 1.0 (0x4000).
  function automatic logic [CORDIC_WIDTH-1:0] angle_step(input int unsigned i);
    logic [CORDIC_WIDTH-1:0] one_w;
    one_w = {{(CORDIC_WIDTH-1){1'b0}}, 1'b1};
    return one_w << (CORDIC_FRAC - i);
  endfunction

endpackage

// File: rtl/cordic_lin_mult_ctrl.sv
// -----------------------------------------------------------------------------
// cordic_lin_mult_ctrl
// Iterative linear-mode CORDIC multiplier controller: y = x * z in Q1.14,
// one micro-rotation per clock. The y accumulation is done by an external
// 16-bit signed adder so adder variants can be swapped without touching
// this block; this controller drives its operands and registers its sum.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   operand handshake (x_in, z_in, signed Q1.14)
//   out_valid/out_ready result handshake (y_out product, z_res residual)
//   add_a, add_b        adder operands: y accumulator and +/-(x >>> i)
//   add_o               adder sum, WIDTH+1 bits sign-extended
//
// WIDTH must equal cordic_pkg::CORDIC_WIDTH (the saturation helper is
// Q1.14 specific).
// -----------------------------------------------------------------------------
module cordic_lin_mult_ctrl
  import cordic_pkg::*;
#(
  parameter int WIDTH = CORDIC_WIDTH,
  parameter int ITER  = 14,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_res,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH:0]   add_o
);

  localparam logic [CNT_W-1:0] LAST_I  = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_n_s;
  logic [WIDTH-1:0]  x_r;
  logic [WIDTH-1:0]  y_r;
  logic [WIDTH-1:0]  z_r;
  logic [CNT_W-1:0]  i_r;
  logic [WIDTH-1:0]  y_out_r;
  logic [WIDTH-1:0]  z_res_r;

  logic              d_pos_s;
  logic              last_s;
  logic [WIDTH-1:0]  x_shift_s;
  logic [WIDTH-1:0]  rot_b_s;
  logic [WIDTH-1:0]  step_s;
  logic [WIDTH-1:0]  z_next_s;
  logic [WIDTH-1:0]  y_sat_s;

  // Rotation direction, shifted multiplicand, residual update and saturated sum.
  always_comb begin
    // z == 0 has a clear sign bit and therefore takes the +1 direction.
    d_pos_s   = ~z_r[WIDTH-1];
    last_s    = (i_r == LAST_I);
    x_shift_s = WIDTH'($signed(x_r) >>> i_r);
    step_s    = angle_step(int'(i_r));
    if (d_pos_s) begin
      rot_b_s  = x_shift_s;
      z_next_s = z_r - step_s;
    end else begin
      rot_b_s  = (~x_shift_s) + ONE_W;
      z_next_s = z_r + step_s;
    end
    y_sat_s = sat_q114(add_o);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_n_s = RUN;
        end else begin
          state_n_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_n_s = DONE;
        end else begin
          state_n_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = DONE;
        end
      end
      default: state_n_s = IDLE;
    endcase
  end

  // Datapath registers: operand capture, micro-rotation update, result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r     <= ZERO_W;
      y_r     <= ZERO_W;
      z_r     <= ZERO_W;
      i_r     <= {CNT_W{1'b0}};
      y_out_r <= ZERO_W;
      z_res_r <= ZERO_W;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            x_r <= x_in;
            z_r <= z_in;
            y_r <= ZERO_W;
            i_r <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          y_r <= y_sat_s;
          z_r <= z_next_s;
          i_r <= i_r + ONE_CNT;
          // Result registers load on the final rotation so they are already
          // valid on the first DONE cycle and hold afterwards.
          if (last_s) begin
            y_out_r <= y_sat_s;
            z_res_r <= z_next_s;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from registered state; adder operands only driven in RUN.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = ZERO_W;
    add_b     = ZERO_W;
    case (state_r)
      IDLE: in_ready = 1'b1;
      RUN: begin
        add_a = y_r;
        add_b = rot_b_s;
      end
      DONE: out_valid = 1'b1;
      default: begin
      end
    endcase
  end

  assign y_out = y_out_r;
  assign z_res = z_res_r;

endmodule

// File: tb/tb_cordic_lin_mult_ctrl.sv
module tb_cordic_lin_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x_in = 16'h0000;
  logic [15:0] z_in = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] y_out;
  logic [15:0] z_res;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [16:0] add_o;

  logic        inj_en = 1'b0;
  logic [16:0] inj_val = 17'h00000;

  typedef struct packed {
    logic [15:0] y;
    logic [15:0] z;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  cordic_lin_mult_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .z_res(z_res),
    .add_a(add_a), .add_b(add_b), .add_o(add_o)
  );

  always #5 clk = ~clk;

  // Exact behavioural adder, with an override to inject overflowing sums.
  always_comb begin
    if (inj_en) add_o = inj_val;
    else        add_o = {add_a[15], add_a} + {add_b[15], add_b};
  end

  function automatic logic [15:0] sat17(input logic [16:0] o);
    if (o[16] != o[15]) return o[16] ? 16'h8000 : 16'h7FFF;
    else return o[15:0];
  endfunction

  // Reference CORDIC linear-mode multiply; inj_idx < 0 means no injection.
  function automatic void model(input logic [15:0] x, input logic [15:0] z0,
                                input int inj_idx, input logic [16:0] iv,
                                output logic [15:0] y_e, output logic [15:0] z_e);
    logic [15:0] y, z, xs, b, st;
    logic [16:0] o;
    y = 16'h0000;
    z = z0;
    for (int i = 0; i < 14; i++) begin
      xs = $signed(x) >>> i;
      st = 16'h0001 << (14 - i);
      b  = z[15] ? (16'h0000 - xs) : xs;
      o  = (i == inj_idx) ? iv : ({y[15], y} + {b[15], b});
      y  = sat17(o);
      z  = z[15] ? (z + st) : (z - st);
    end
    y_e = y;
    z_e = z;
  endfunction

  // One full operation with out_ready held high; observed result returned.
  task automatic do_op(input logic [15:0] x, input logic [15:0] z,
                       input int inj_idx, input logic [16:0] iv, input string name,
                       output logic [15:0] y_obs, output logic [15:0] z_obs);
    logic [15:0] ye, ze, b0;
    exp_t e;
    int k;
    model(x, z, inj_idx, iv, ye, ze);
    sb.push_back({ye, ze});
    checks++;
    if (in_ready !== 1'b1) $display("FAIL %s idle_ready: got %b want 1", name, in_ready);
    else passes++;
    out_ready = 1'b1;
    x_in = x; z_in = z; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    b0 = z[15] ? (16'h0000 - x) : x;
    checks++;
    if (add_a !== 16'h0000 || add_b !== b0)
      $display("FAIL %s first_run_ops: got a=%h b=%h want a=0000 b=%h", name, add_a, add_b, b0);
    else passes++;
    k = 0;
    while (!out_valid && k < 40) begin
      inj_en = (k == inj_idx);
      inj_val = iv;
      @(posedge clk); #1;
      inj_en = 1'b0;
      k++;
      if (inj_idx >= 0 && k == inj_idx + 1) begin
        checks++;
        if (add_a !== sat17(iv)) $display("FAIL %s sat_acc: got %h want %h", name, add_a, sat17(iv));
        else passes++;
      end
    end
    checks++;
    if (k !== 14) $display("FAIL %s latency: got %0d want 14", name, k);
    else passes++;
    y_obs = y_out;
    z_obs = z_res;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s scoreboard: empty queue", name);
    end else begin
      e = sb.pop_front();
      if (y_out !== e.y || z_res !== e.z)
        $display("FAIL %s result: got y=%h z=%h want y=%h z=%h", name, y_out, z_res, e.y, e.z);
      else passes++;
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s back_to_idle: got ov=%b rdy=%b want 0 1", name, out_valid, in_ready);
    else passes++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y_out !== 16'h0000 || z_res !== 16'h0000 ||
        add_a !== 16'h0000 || add_b !== 16'h0000)
      $display("FAIL reset_state: got rdy=%b ov=%b y=%h z=%h a=%h b=%h want 1 0 0 0 0 0",
               in_ready, out_valid, y_out, z_res, add_a, add_b);
    else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multiply;
    logic [15:0] y, z;
    do_op(16'h2000, 16'h2000, -1, 17'h0, "half_x_half", y, z);
    checks++;
    if (y !== 16'h1001 || z !== 16'hFFFE)
      $display("FAIL half_x_half_const: got y=%h z=%h want y=1001 z=fffe", y, z);
    else passes++;
    do_op(16'h2000, 16'h0000, -1, 17'h0, "z_zero", y, z);
    checks++;
    if (y !== 16'h0001) $display("FAIL z_zero_const: got %h want 0001", y);
    else passes++;
    do_op(16'h2000, 16'hE000, -1, 17'h0, "z_neg", y, z);
    checks++;
    if (y !== 16'hF001) $display("FAIL z_neg_const: got %h want f001", y);
    else passes++;
    do_op(16'hD000, 16'h3000, -1, 17'h0, "x_neg", y, z);
  endtask

  task automatic test_saturation;
    logic [15:0] y, z;
    do_op(16'h2000, 16'h2000, 3, 17'h08000, "sat_pos", y, z);
    do_op(16'h2000, 16'h2000, 5, 17'h17FFF, "sat_neg", y, z);
  endtask

  task automatic test_backpressure;
    logic [15:0] ya, za, yb, zb;
    exp_t e;
    int k;
    int busy_rdy;
    model(16'h2000, 16'h2000, -1, 17'h0, ya, za);
    sb.push_back({ya, za});
    out_ready = 1'b0;
    x_in = 16'h2000; z_in = 16'h2000; in_valid = 1'b1;
    @(posedge clk); #1;
    // Second pair offered while busy; it must wait for IDLE.
    x_in = 16'h1000; z_in = 16'h3000;
    k = 0; busy_rdy = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (in_ready) busy_rdy++;
    end
    checks++;
    if (k !== 14) $display("FAIL bp_latency: got %0d want 14", k);
    else passes++;
    checks++;
    if (busy_rdy !== 0) $display("FAIL bp_busy_ready: got %0d ready cycles want 0", busy_rdy);
    else passes++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || y_out !== ya || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got ov=%b y=%h rdy=%b want 1 %h 0", c, out_valid, y_out, in_ready, ya);
      else passes++;
    end
    out_ready = 1'b1;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL bp_result_a: empty queue");
    end else begin
      e = sb.pop_front();
      if (y_out !== e.y || z_res !== e.z)
        $display("FAIL bp_result_a: got y=%h z=%h want y=%h z=%h", y_out, z_res, e.y, e.z);
      else passes++;
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_idle: got ov=%b rdy=%b want 0 1", out_valid, in_ready);
    else passes++;
    model(16'h1000, 16'h3000, -1, 17'h0, yb, zb);
    sb.push_back({yb, zb});
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || add_b !== 16'h1000)
      $display("FAIL bp_accept_b: got rdy=%b b=%h want 0 1000", in_ready, add_b);
    else passes++;
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (sb.size() == 0 || k !== 14) begin
      $display("FAIL bp_result_b: latency %0d want 14 or empty queue", k);
    end else begin
      e = sb.pop_front();
      if (y_out !== e.y || z_res !== e.z)
        $display("FAIL bp_result_b: got y=%h z=%h want y=%h z=%h", y_out, z_res, e.y, e.z);
      else passes++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [15:0] y, z;
    int pulses;
    x_in = 16'h2000; z_in = 16'h2000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || add_a !== 16'h0000 || add_b !== 16'h0000 || y_out !== 16'h0000)
      $display("FAIL mid_reset_idle: got rdy=%b ov=%b a=%h b=%h y=%h want 1 0 0 0 0",
               in_ready, out_valid, add_a, add_b, y_out);
    else passes++;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) $display("FAIL mid_reset_no_valid: got %0d pulses want 0", pulses);
    else passes++;
    do_op(16'h2000, 16'h2000, -1, 17'h0, "after_reset", y, z);
    checks++;
    if (y !== 16'h1001 || z !== 16'hFFFE)
      $display("FAIL after_reset_const: got y=%h z=%h want y=1001 z=fffe", y, z);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
